// File: rtl/hdmi_video_out_if.sv
// hdmi_video_out_if: display-side bundle of memory read ports, PPU handshake and video outputs.
interface hdmi_video_out_if;
   logic [8:0]  hdmi_rowram_rdaddr;
   logic [9:0]  hdmi_rowram_rddata;
   logic [8:0]  hdmi_palram_rdaddr;
   logic [63:0] hdmi_palram_rddata;
   logic        rowram_swap;
   logic [7:0]  next_row;
   logic        vblank_start;
   logic        vblank_end_soon;
   logic [23:0] hdmi_rgb;
   logic        hdmi_hsync;
   logic        hdmi_vsync;
   logic        hdmi_de;
   modport master (
      output hdmi_rowram_rdaddr, hdmi_palram_rdaddr, rowram_swap, next_row, vblank_start,
             vblank_end_soon, hdmi_rgb, hdmi_hsync, hdmi_vsync, hdmi_de,
      input  hdmi_rowram_rddata, hdmi_palram_rddata
   );
   modport slave (
      input  hdmi_rowram_rdaddr, hdmi_palram_rdaddr, rowram_swap, next_row, vblank_start,
             vblank_end_soon, hdmi_rgb, hdmi_hsync, hdmi_vsync, hdmi_de,
      output hdmi_rowram_rddata, hdmi_palram_rddata
   );
endinterface

// File: rtl/hdmi_video_out.sv
// hdmi_video_out: 640x480@60 timing, 2x-doubled row-RAM/palette fetch and PPU row handshake.
module hdmi_video_out #(
   parameter int VEND_SOON_LINE = 520
) (
   input logic              clk,
   input logic              rst_n,
   hdmi_video_out_if.master vid
);
   logic [9:0]  h_q, h_d, v_q, v_d;
   logic [2:0]  de_q, hs_q, vs_q;
   logic        half_q;
   logic [23:0] rgb_q, rgb_d;
   logic        swap_q, swap_d, vbs_q, vbs_d, ves_q, ves_d;
   logic [7:0]  nrow_q, nrow_d;
   logic        vis, raw_hs, raw_vs, unused_pal;
   always_comb begin
      h_d    = (h_q == 10'd799) ? 10'd0 : h_q + 10'd1;
      v_d    = (h_q != 10'd799) ? v_q : (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
      vis    = (h_q < 10'd640) && (v_q < 10'd480);
      raw_hs = !((h_q >= 10'd656) && (h_q <= 10'd751));
      raw_vs = !((v_q >= 10'd490) && (v_q <= 10'd491));
      vbs_d  = (h_q == 10'd0) && (v_q == 10'd480);
      ves_d  = (h_q == 10'd0) && (v_q == 10'(VEND_SOON_LINE));
      // swap after the second line of each game row, plus two pre-frame swaps in vblank
      swap_d = (h_q == 10'd640) && ((v_q >= 10'd523) || (v_q[0] && (v_q <= 10'd477)));
      nrow_d = !swap_d ? nrow_q :
               (v_q == 10'd523) ? 8'd0 :
               (v_q == 10'd524) ? 8'd1 : 8'((v_q + 10'd3) >> 1);
      // de_q[1] is the visibility of the pixel whose palette word is on the bus now
      rgb_d  = !de_q[1] ? 24'd0 :
               half_q ? vid.hdmi_palram_rddata[55:32] : vid.hdmi_palram_rddata[23:0];
   end
   assign vid.hdmi_rowram_rdaddr = (h_q < 10'd640) ? h_q[9:1] : 9'd0;
   assign vid.hdmi_palram_rdaddr = vid.hdmi_rowram_rddata[9:1];
   assign unused_pal = ^{vid.hdmi_palram_rddata[63:56], vid.hdmi_palram_rddata[31:24]};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q    <= 10'd0;
         v_q    <= 10'd0;
         de_q   <= 3'b000;
         hs_q   <= 3'b111;
         vs_q   <= 3'b111;
         half_q <= 1'b0;
         rgb_q  <= 24'd0;
         swap_q <= 1'b0;
         vbs_q  <= 1'b0;
         ves_q  <= 1'b0;
         nrow_q <= 8'd0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         de_q   <= {de_q[1:0], vis};
         hs_q   <= {hs_q[1:0], raw_hs};
         vs_q   <= {vs_q[1:0], raw_vs};
         half_q <= vid.hdmi_rowram_rddata[0];
         rgb_q  <= rgb_d;
         swap_q <= swap_d;
         vbs_q  <= vbs_d;
         ves_q  <= ves_d;
         nrow_q <= nrow_d;
      end
   end
   assign vid.hdmi_rgb        = rgb_q;
   assign vid.hdmi_de         = de_q[2];
   assign vid.hdmi_hsync      = hs_q[2];
   assign vid.hdmi_vsync      = vs_q[2];
   assign vid.rowram_swap     = swap_q;
   assign vid.next_row        = nrow_q;
   assign vid.vblank_start    = vbs_q;
   assign vid.vblank_end_soon = ves_q;
endmodule
